txreq_arb_lcrd: RTL and testbench
=================================

# txreq_arb_lcrd

Shares the single CHI TXREQ link between several internal requesters of the home node, such as the SLC ReadNoSnp path and the POCQ retry/writeback path. It tracks link-layer credits granted by the downstream node and issues at most one flit per cycle, only when a credit is held. It also runs the link-deactivation sequence, returning every held credit with LCrdReturn flits before reporting the link stopped. It sits between the SLC→TXREQ pipeline stage(s) and the TXREQ pins of the HN-F top level.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesters; index 0 is the SLC path.
- `MAX_CRD`, 15: maximum L-credits the downstream node may grant (CHI limit).
- `CRD_W`, $clog2(MAX_CRD+1): credit counter width; derived, not overridden.

Ports:
- `clock`  in  1: single clock.
- `reset`  in  1: asynchronous, active-low.
- `req_valid`  in  NUM_REQ: requester i has a flit.
- `req_flit`  in  NUM_REQ × reqflit_t: flit per requester; held stable while valid and not ready.
- `req_ready`  out  NUM_REQ: flit i accepted this cycle (combinational).
- `link_deact_req`  in  1: level; high requests link deactivation.
- `TXREQFLIT`  out  reqflit_t: outgoing flit (registered).
- `TXREQFLITV`  out  1: flit valid (registered).
- `TXREQFLITPEND`  out  1: flit-pending indication.
- `TXREQLCRDV`  in  1: one L-credit granted this cycle.
- `crd_cnt`  out  CRD_W: credits currently held.
- `link_stopped`  out  1: state == STOP.

## Operation
- States:
  - STOP (reset state): no grants and no flits sent. Goes to RUN on the first cycle `link_deact_req`=0.
  - RUN: normal arbitration. Goes to RETURN on the first cycle `link_deact_req`=1; grants are suppressed combinationally in that same cycle.
  - RETURN: sends one LCrdReturn flit (opcode REQ_LCRD_RETURN = 0x00, all other fields 0) per cycle while `crd_cnt`>0. Goes to STOP when `crd_cnt`==0 and `TXREQLCRDV`=0.
- Credit counter:
  - +1 on `TXREQLCRDV`.
  - −1 on every flit launched, request or return.
  - Both in the same cycle: the counter is unchanged.
  - Credits arriving in STOP are counted; they are spent in RUN or returned in the next RETURN.
- Grant rules:
  - In RUN with `crd_cnt`>0 (current value, not including this cycle's LCRDV), exactly one valid requester is granted.
  - `req_ready[i]` = grant[i]. A handshake occurs when valid and ready are both high.
- Round-robin:
  - The pointer `rr_ptr` (reset 0) is the highest-priority index. The search runs `rr_ptr`, `rr_ptr`+1, … mod NUM_REQ.
  - On a handshake with requester k, `rr_ptr` ← (k+1) mod NUM_REQ. With no handshake the pointer holds.
- Reset values: `req_ready`=0, `TXREQFLITV`=0, `TXREQFLIT`=0, `TXREQFLITPEND`=0, `crd_cnt`=0, `link_stopped`=1, `rr_ptr`=0.
- Credit overflow (LCRDV with `crd_cnt`==MAX_CRD) is a protocol error. The counter saturates and the credit is dropped.

## Timing
- Handshake in cycle N → `TXREQFLIT`/`TXREQFLITV` high in N+1 for exactly one cycle.
- Back-to-back handshakes give one flit per cycle while credits last.
- An LCrdReturn decided in cycle N is on the pins in N+1.
- `TXREQFLITPEND` is registered, =1 whenever next-state ≠ STOP. It is therefore high at least one cycle before any `TXREQFLITV`.
- `crd_cnt` updates at the clock edge after the send or LCRDV event.
- `crd_cnt`=1 with a handshake and LCRDV in cycle N → `crd_cnt`=1 in N+1, and a grant is possible in N+1.
- `link_deact_req` rising in the same cycle as a pending valid → no grant; the requester keeps waiting.
- Reset asserted mid-operation clears all state immediately. The flit in flight is discarded and held credits are lost; the partner is reset together with this block.

## Configuration
- `TXREQ_ARB_QOS_EN` defined: arbitration first selects the valid requesters with the maximum `req_flit[i].QoS`, then applies round-robin among those. The pointer update is unchanged.
- Undefined: pure round-robin; `QoS` is ignored.

## Structure
- REQ_LCRD_RETURN and the state enum (`txreq_lcrd_state_e`: STOP/RUN/RETURN) go in chi_flit.vh / chi_cache.vh alongside `reqflit_t`. MAX_CRD defaults go in autoconfig.vh.
- One sub-module: `rr_arbiter` (parameter NUM_REQ; inputs req, ptr, optional mask; output one-hot grant).

## Test plan
- After reset: one cycle with `link_deact_req`=0, 3 LCRDV pulses, `req_valid`=2'b11 held → grants 0,1,0 on consecutive cycles; 3 flits out starting one cycle after the first grant; `crd_cnt`=0 afterwards; req1 stays waiting.
- `crd_cnt`=0 with a valid pending → `req_ready`=0. LCRDV in cycle N → grant in N+1, flit in N+2.
- Handshake and LCRDV in the same cycle with `crd_cnt`=1 → `crd_cnt` stays 1.
- `crd_cnt`=4 and `link_deact_req`→1 → 4 LCrdReturn flits (opcode 0x00) on consecutive cycles, no requester grants. An extra LCRDV during RETURN → 5 returns. `link_stopped`=1 after the last return; `TXREQFLITPEND` goes low.
- With `TXREQ_ARB_QOS_EN`: req0 QoS=2 and req1 QoS=9, both valid, `rr_ptr`=0 → req1 granted first.
- Reset asserted while `crd_cnt`=5 and a flit is in flight → all outputs return to reset values asynchronously; `crd_cnt`=0.

Source files
------------

// File: rtl/txreq_arb_lcrd_pkg.sv
// txreq_arb_lcrd_pkg: CHI TXREQ flit layout, link-credit state encoding and
// defaults shared by the TXREQ arbiter and its round-robin sub-module.
package txreq_arb_lcrd_pkg;

    typedef struct packed {
        logic [3:0]  QoS;
        logic [6:0]  TgtID;
        logic [6:0]  SrcID;
        logic [7:0]  TxnID;
        logic [5:0]  Opcode;
        logic [23:0] Addr;
    } reqflit_t;

    localparam logic [5:0] REQ_LCRD_RETURN = 6'h00;
    localparam int         MAX_CRD_DEF     = 15;

    typedef enum logic [1:0] {
        STOP,
        RUN,
        RETURN
    } txreq_lcrd_state_e;

endpackage

// File: rtl/txreq_arb_lcrd_rr_arbiter.sv
// rr_arbiter: one-hot round-robin pick among req & mask, starting at ptr.
//   req   in  NUM_REQ  candidate requesters
//   ptr   in  PTR_W    highest-priority index
//   mask  in  NUM_REQ  extra qualifier (all ones when unused)
//   grant out NUM_REQ  one-hot grant, zero when nothing qualifies
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    input  logic [NUM_REQ-1:0] mask,
    output logic [NUM_REQ-1:0] grant
);

    int   j;
    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        j     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = (int'(ptr) + i) % NUM_REQ;
            if (!found && req[j] && mask[j]) begin
                grant[j] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/txreq_arb_lcrd.sv
// txreq_arb_lcrd: shares the CHI TXREQ link among NUM_REQ requesters, tracks
// link-layer credits and runs the deactivation (LCrdReturn) sequence.
//   clock/reset        clock, asynchronous active-low reset
//   req_valid/flit     per-requester flit offer; req_ready is the grant
//   link_deact_req     level request to deactivate the link
//   TXREQFLIT[V|PEND]  registered TXREQ pins; TXREQLCRDV credit grant in
//   crd_cnt            credits held; link_stopped high in STOP
// Macro TXREQ_ARB_QOS_EN: restrict round-robin to the highest-QoS requesters.
module txreq_arb_lcrd
    import txreq_arb_lcrd_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int MAX_CRD  = MAX_CRD_DEF,
    localparam int CRD_W   = $clog2(MAX_CRD + 1)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_REQ-1:0]  req_valid,
    input  reqflit_t            req_flit [NUM_REQ],
    output logic [NUM_REQ-1:0]  req_ready,
    input  logic                link_deact_req,
    output reqflit_t            TXREQFLIT,
    output logic                TXREQFLITV,
    output logic                TXREQFLITPEND,
    input  logic                TXREQLCRDV,
    output logic [CRD_W-1:0]    crd_cnt,
    output logic                link_stopped
);

    localparam int               PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [CRD_W-1:0] CRD_TOP = CRD_W'(MAX_CRD);

    txreq_lcrd_state_e  state_q, state_d;
    logic [CRD_W-1:0]   crd_q, crd_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    reqflit_t           flit_q, flit_d;
    logic               flitv_q, flitv_d;
    logic               pend_q, pend_d;

    logic               grant_en, send_req, send_ret, launch;
    logic [NUM_REQ-1:0] mask, grant;
    logic [PTR_W-1:0]   gidx;

`ifdef TXREQ_ARB_QOS_EN
    logic [3:0] max_qos;

    always_comb begin
        max_qos = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (req_valid[i] && req_flit[i].QoS > max_qos)
                max_qos = req_flit[i].QoS;
        for (int i = 0; i < NUM_REQ; i++)
            mask[i] = req_flit[i].QoS == max_qos;
    end
`else
    assign mask = '1;
`endif

    // Deactivation request blocks grants in the very cycle it is seen.
    assign grant_en = state_q == RUN && !link_deact_req && crd_q != '0;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req   (req_valid & {NUM_REQ{grant_en}}),
        .ptr   (rr_ptr_q),
        .mask  (mask),
        .grant (grant)
    );

    assign req_ready = grant;
    assign send_req  = |grant;
    assign send_ret  = state_q == RETURN && crd_q != '0;
    assign launch    = send_req || send_ret;

    always_comb begin
        gidx = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (grant[i])
                gidx = PTR_W'(i);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            STOP:    state_d = link_deact_req ? STOP : RUN;
            RUN:     state_d = link_deact_req ? RETURN : RUN;
            RETURN:  state_d = (crd_q == '0 && !TXREQLCRDV) ? STOP : RETURN;
            default: state_d = STOP;
        endcase
        // A credit arriving at the limit is dropped unless one is spent alongside.
        crd_d    = (TXREQLCRDV && !launch) ? ((crd_q == CRD_TOP) ? crd_q : crd_q + 1'b1) :
                   (!TXREQLCRDV && launch) ? crd_q - 1'b1 : crd_q;
        rr_ptr_d = !send_req ? rr_ptr_q :
                   (gidx == PTR_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
        flit_d   = '0;
        if (send_req)
            flit_d = req_flit[gidx];
        else if (send_ret)
            flit_d.Opcode = REQ_LCRD_RETURN;
        flitv_d  = launch;
        pend_d   = state_d != STOP;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= STOP;
            crd_q    <= '0;
            rr_ptr_q <= '0;
            flit_q   <= '0;
            flitv_q  <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            crd_q    <= crd_d;
            rr_ptr_q <= rr_ptr_d;
            flit_q   <= flit_d;
            flitv_q  <= flitv_d;
            pend_q   <= pend_d;
        end
    end

    assign TXREQFLIT     = flit_q;
    assign TXREQFLITV    = flitv_q;
    assign TXREQFLITPEND = pend_q;
    assign crd_cnt       = crd_q;
    assign link_stopped  = state_q == STOP;

endmodule

// File: tb/tb_txreq_arb_lcrd.sv
// tb_txreq_arb_lcrd: directed bench for txreq_arb_lcrd with hand-computed expectations.
module tb_txreq_arb_lcrd;
    import txreq_arb_lcrd_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] req_valid = 2'b00;
    reqflit_t   req_flit [2];
    logic [1:0] req_ready;
    logic       link_deact_req = 1'b1;
    reqflit_t   TXREQFLIT;
    logic       TXREQFLITV;
    logic       TXREQFLITPEND;
    logic       TXREQLCRDV = 1'b0;
    logic [3:0] crd_cnt;
    logic       link_stopped;

    int n_chk = 0;
    int n_err = 0;

    reqflit_t f0, f1, fret;

    txreq_arb_lcrd dut (
        .clock          (clock),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_flit       (req_flit),
        .req_ready      (req_ready),
        .link_deact_req (link_deact_req),
        .TXREQFLIT      (TXREQFLIT),
        .TXREQFLITV     (TXREQFLITV),
        .TXREQFLITPEND  (TXREQFLITPEND),
        .TXREQLCRDV     (TXREQLCRDV),
        .crd_cnt        (crd_cnt),
        .link_stopped   (link_stopped)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic nxt;
        @(posedge clock);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, 64'(req_ready), 64'(0));
        chk({tag, "_flitv"}, 64'(TXREQFLITV), 64'(0));
        chk({tag, "_flit"}, 64'(TXREQFLIT), 64'(0));
        chk({tag, "_pend"}, 64'(TXREQFLITPEND), 64'(0));
        chk({tag, "_crd"}, 64'(crd_cnt), 64'(0));
        chk({tag, "_stopped"}, 64'(link_stopped), 64'(1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        f0   = '{QoS: 4'd0, TgtID: 7'd3, SrcID: 7'd1, TxnID: 8'h10, Opcode: 6'h04, Addr: 24'h001000};
        f1   = '{QoS: 4'd0, TgtID: 7'd3, SrcID: 7'd1, TxnID: 8'h21, Opcode: 6'h01, Addr: 24'h002040};
        fret = '0;
        req_flit[0] = f0;
        req_flit[1] = f1;
        @(negedge clock);
        chk_reset_vals("rst");
        nxt;
        reset = 1'b1;
        // grants 0,1,0 under 3 credits
        link_deact_req = 1'b0;
        TXREQLCRDV = 1'b1;
        @(negedge clock);
        chk("c0_ready", 64'(req_ready), 64'(0));
        nxt;
        req_valid = 2'b11;
        @(negedge clock);
        chk("c1_crd", 64'(crd_cnt), 64'(1));
        chk("c1_pend", 64'(TXREQFLITPEND), 64'(1));
        chk("c1_ready", 64'(req_ready), 64'(2'b01));
        chk("c1_flitv", 64'(TXREQFLITV), 64'(0));
        nxt;
        @(negedge clock);
        chk("c2_crd_same", 64'(crd_cnt), 64'(1));
        chk("c2_ready", 64'(req_ready), 64'(2'b10));
        chk("c2_flitv", 64'(TXREQFLITV), 64'(1));
        chk("c2_flit", 64'(TXREQFLIT), 64'(f0));
        nxt;
        TXREQLCRDV = 1'b0;
        @(negedge clock);
        chk("c3_crd", 64'(crd_cnt), 64'(1));
        chk("c3_ready", 64'(req_ready), 64'(2'b01));
        chk("c3_flit", 64'(TXREQFLIT), 64'(f1));
        nxt;
        @(negedge clock);
        chk("c4_crd", 64'(crd_cnt), 64'(0));
        chk("c4_ready", 64'(req_ready), 64'(0));
        chk("c4_flitv", 64'(TXREQFLITV), 64'(1));
        chk("c4_flit", 64'(TXREQFLIT), 64'(f0));
        nxt;
        // no credit: req1 waits; credit in N -> grant N+1 -> flit N+2
        @(negedge clock);
        chk("c5_ready", 64'(req_ready), 64'(0));
        chk("c5_flitv", 64'(TXREQFLITV), 64'(0));
        nxt;
        TXREQLCRDV = 1'b1;
        @(negedge clock);
        chk("c6_ready", 64'(req_ready), 64'(0));
        nxt;
        TXREQLCRDV = 1'b0;
        @(negedge clock);
        chk("c7_ready", 64'(req_ready), 64'(2'b10));
        chk("c7_flitv", 64'(TXREQFLITV), 64'(0));
        nxt;
        req_valid = 2'b00;
        @(negedge clock);
        chk("c8_flitv", 64'(TXREQFLITV), 64'(1));
        chk("c8_flit", 64'(TXREQFLIT), 64'(f1));
        chk("c8_crd", 64'(crd_cnt), 64'(0));
        nxt;
        // collect 4 credits, then deactivate with requesters pending
        TXREQLCRDV = 1'b1;
        for (int i = 0; i < 4; i++) nxt;
        TXREQLCRDV = 1'b0;
        req_valid = 2'b11;
        link_deact_req = 1'b1;
        @(negedge clock);
        chk("d0_crd", 64'(crd_cnt), 64'(4));
        chk("d0_ready_suppr", 64'(req_ready), 64'(0));
        nxt;
        TXREQLCRDV = 1'b1;
        @(negedge clock);
        chk("d1_ready", 64'(req_ready), 64'(0));
        chk("d1_flitv", 64'(TXREQFLITV), 64'(0));
        chk("d1_stopped", 64'(link_stopped), 64'(0));
        nxt;
        TXREQLCRDV = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk($sformatf("ret%0d_flitv", i), 64'(TXREQFLITV), 64'(1));
            chk($sformatf("ret%0d_flit", i), 64'(TXREQFLIT), 64'(fret));
            chk($sformatf("ret%0d_ready", i), 64'(req_ready), 64'(0));
            chk($sformatf("ret%0d_crd", i), 64'(crd_cnt), 64'(4 - i));
            chk($sformatf("ret%0d_pend", i), 64'(TXREQFLITPEND), 64'(1));
            nxt;
        end
        @(negedge clock);
        chk("d7_flitv", 64'(TXREQFLITV), 64'(0));
        chk("d7_stopped", 64'(link_stopped), 64'(1));
        chk("d7_pend", 64'(TXREQFLITPEND), 64'(0));
        chk("d7_ready", 64'(req_ready), 64'(0));
        nxt;
        // build 6 credits, launch one, then reset with a flit in flight
        req_valid = 2'b00;
        link_deact_req = 1'b0;
        TXREQLCRDV = 1'b1;
        for (int i = 0; i < 6; i++) nxt;
        TXREQLCRDV = 1'b0;
        req_valid = 2'b01;
        @(negedge clock);
        chk("r0_crd", 64'(crd_cnt), 64'(6));
        chk("r0_ready", 64'(req_ready), 64'(2'b01));
        nxt;
        req_valid = 2'b00;
        #1;
        chk("r1_crd", 64'(crd_cnt), 64'(5));
        chk("r1_flitv", 64'(TXREQFLITV), 64'(1));
        reset = 1'b0;
        #1;
        chk_reset_vals("arst");
        nxt;
        reset = 1'b1;
        // QoS selection with rr_ptr at 0
        f0.QoS = 4'd2;
        f1.QoS = 4'd9;
        req_flit[0] = f0;
        req_flit[1] = f1;
        TXREQLCRDV = 1'b1;
        nxt;
        TXREQLCRDV = 1'b0;
        req_valid = 2'b11;
        @(negedge clock);
`ifdef TXREQ_ARB_QOS_EN
        chk("qos_ready", 64'(req_ready), 64'(2'b10));
`else
        chk("qos_ready", 64'(req_ready), 64'(2'b01));
`endif
        nxt;
        req_valid = 2'b00;
        @(negedge clock);
`ifdef TXREQ_ARB_QOS_EN
        chk("qos_flit", 64'(TXREQFLIT), 64'(f1));
`else
        chk("qos_flit", 64'(TXREQFLIT), 64'(f0));
`endif
        chk("qos_crd", 64'(crd_cnt), 64'(0));
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
